fetch_pc_unit: RTL and testbench

- Instruction-fetch / program-counter stage sitting directly upstream of the control decoder.
- Holds the PC and drives it to the external combinational instruction ROM. The opcode field of the returned instruction goes to the decoder.
- Consumes the decoder's UncondJump/JType and the ALU compare result to select the next PC.
- Owns the Start/Done run handshake and the compare-flag register.

---
 rtl/isa_pkg.sv | 21 ++
 rtl/jump_lut.sv | 11 +
 rtl/fetch_pc_unit.sv | 55 +++++
 tb/tb_fetch_pc_unit.sv | 155 +++++++++++++++
 4 files changed

// File: rtl/isa_pkg.sv
// isa_pkg: shared opcodes, fetch states and the default jump table
package isa_pkg;
  localparam int DEF_PC_W = 10;
  localparam int DEF_INSTR_W = 9;
  localparam int DEF_OP_W = 4;
  localparam int DEF_IDX_W = 5;
  localparam logic [3:0] OP_JMP = 4'b0000;
  localparam logic [3:0] OP_BEQ = 4'b0001;
  localparam logic [3:0] OP_BNE = 4'b0010;
  localparam logic [3:0] OP_BLT = 4'b0011;
  localparam logic [3:0] OP_BGE = 4'b0100;
  localparam logic [3:0] OP_HALT = 4'b1111;
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} fetch_state_t;
  typedef logic [2**DEF_IDX_W-1:0][DEF_PC_W-1:0] lut_t;
  function automatic lut_t default_lut();
    lut_t t;
    for (int k = 0; k < 2**DEF_IDX_W; k++) t[k] = DEF_PC_W'(8 * k);
    return t;
  endfunction
  localparam lut_t JUMP_LUT = default_lut();
endpackage

// File: rtl/jump_lut.sv
// jump_lut: combinational jump-index to absolute PC target lookup
module jump_lut import isa_pkg::*; #(
  parameter int IDX_W = DEF_IDX_W,
  parameter int PC_W = DEF_PC_W,
  parameter logic [2**IDX_W-1:0][PC_W-1:0] LUT = JUMP_LUT
) (
  input  logic [IDX_W-1:0] idx,
  output logic [PC_W-1:0]  target
);
  assign target = LUT[idx];
endmodule

// File: rtl/fetch_pc_unit.sv
// fetch_pc_unit: program counter, run handshake and compare flags for the fetch stage
module fetch_pc_unit import isa_pkg::*; #(
  parameter int PC_W = DEF_PC_W,
  parameter int INSTR_W = DEF_INSTR_W,
  parameter int OP_W = DEF_OP_W,
  parameter int IDX_W = DEF_IDX_W,
  parameter logic [2**IDX_W-1:0][PC_W-1:0] LUT = JUMP_LUT
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [INSTR_W-1:0] instr,
  input  logic               uncond_jump,
  input  logic               jtype,
  input  logic               cmp_en,
  input  logic               alu_zero,
  input  logic               alu_neg,
  output logic [PC_W-1:0]    pc,
  output logic               run,
  output logic               taken,
  output logic               done
);
  fetch_state_t state, state_n;
  logic [PC_W-1:0] pc_n, target;
  logic [OP_W-1:0] op;
  logic z, n, cond, halt;
  jump_lut #(.IDX_W(IDX_W), .PC_W(PC_W), .LUT(LUT)) u_lut (
    .idx(instr[IDX_W-1:0]),
    .target(target)
  );
  assign op = instr[INSTR_W-1 -: OP_W];
  assign run = state == S_RUN;
  assign done = state == S_DONE;
  // branch decision from pre-edge flags, then next state/PC with halt > taken > overflow > increment
  always_comb begin
    cond = op == OP_W'(OP_BEQ) ? z : op == OP_W'(OP_BNE) ? !z : op == OP_W'(OP_BLT) ? n : op == OP_W'(OP_BGE) ? !n : 1'b0;
    halt = run && op == OP_W'(OP_HALT);
    taken = run && (uncond_jump || (jtype && cond));
    state_n = !run ? (start ? S_RUN : state) : (halt || (!taken && &pc)) ? S_DONE : S_RUN;
    pc_n = !run ? (start ? '0 : pc) : halt ? pc : taken ? target : &pc ? pc : pc + 1'b1;
  end
  // state, PC and flag registers; flags clear on start and capture on cmp while running
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state <= S_IDLE;
      pc <= '0;
      z <= 1'b0;
      n <= 1'b0;
    end else begin
      state <= state_n;
      pc <= pc_n;
      z <= !run ? (start ? 1'b0 : z) : cmp_en ? alu_zero : z;
      n <= !run ? (start ? 1'b0 : n) : cmp_en ? alu_neg : n;
    end
endmodule

// File: tb/tb_fetch_pc_unit.sv
// tb_fetch_pc_unit: scoreboard bench with a behavioural model of the fetch stage
module tb_fetch_pc_unit;
  logic clk = 0, reset = 0, start = 0, uncond_jump = 0, jtype = 0, cmp_en = 0, alu_zero = 0, alu_neg = 0;
  logic [8:0] instr = '0;
  logic [9:0] pc;
  logic run, taken, done;
  function automatic logic [31:0][9:0] mk_lut();
    logic [31:0][9:0] t;
    for (int k = 0; k < 32; k++) t[k] = (k == 31) ? 10'd1023 : 10'(8 * k);
    return t;
  endfunction
  localparam logic [31:0][9:0] TB_LUT = mk_lut();
  fetch_pc_unit #(.LUT(TB_LUT)) dut (
    .clk(clk), .reset(reset), .start(start), .instr(instr),
    .uncond_jump(uncond_jump), .jtype(jtype), .cmp_en(cmp_en),
    .alu_zero(alu_zero), .alu_neg(alu_neg),
    .pc(pc), .run(run), .taken(taken), .done(done)
  );
  always #5 clk = ~clk;
  typedef struct {int pc; bit run; bit done; bit taken;} exp_t;
  exp_t q[$];
  int checks = 0, fails = 0;
  int m_pc = 0;
  bit m_run = 0, m_done = 0, m_z = 0, m_n = 0;
  function automatic int ref_target(int i);
    return i == 31 ? 1023 : 8 * i;
  endfunction
  task automatic chk(string nm, int act, int exp);
    checks++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d at %0t", nm, act, exp, $time);
    end
  endtask
  always @(negedge clk)
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      chk("pc", int'(pc), e.pc);
      chk("run", int'(run), int'(e.run));
      chk("done", int'(done), int'(e.done));
      chk("taken", int'(taken), int'(e.taken));
    end
  task automatic cyc(bit st, int op, int idx, bit uj, bit jt, bit ce, bit az, bit an, bit rs);
    exp_t e;
    bit cond, tk;
    @(posedge clk);
    #1;
    reset = rs; start = st; instr = {4'(op), 5'(idx)};
    uncond_jump = uj; jtype = jt; cmp_en = ce; alu_zero = az; alu_neg = an;
    if (rs) begin
      m_run = 0; m_done = 0; m_pc = 0; m_z = 0; m_n = 0;
    end
    case (op)
      1: cond = m_z;
      2: cond = !m_z;
      3: cond = m_n;
      4: cond = !m_n;
      default: cond = 0;
    endcase
    tk = m_run && (uj || (jt && cond));
    e = '{m_pc, m_run, m_done, tk};
    q.push_back(e);
    if (!rs) begin
      if (m_run) begin
        if (op == 15) begin
          m_run = 0; m_done = 1;
        end else if (tk) m_pc = ref_target(idx);
        else if (m_pc == 1023) begin
          m_run = 0; m_done = 1;
        end else m_pc++;
        if (ce) begin
          m_z = az; m_n = an;
        end
      end else if (st) begin
        m_run = 1; m_done = 0; m_pc = 0; m_z = 0; m_n = 0;
      end
    end
  endtask
  task automatic nop();
    cyc(0, 5, $urandom_range(0, 31), 0, 0, 0, $urandom_range(0, 1), $urandom_range(0, 1), 0);
  endtask
  task automatic run_to(int target);
    int b = 0;
    while (m_pc != target && b < 1100) begin
      nop();
      b++;
    end
    if (b == 1100) begin
      checks++;
      fails++;
      $display("FAIL run_to: model pc %0d never reached %0d", m_pc, target);
    end
  endtask
  initial begin
    int b;
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 1);
    cyc(0, 5, 0, 0, 0, 0, 0, 0, 0);
    cyc(1, 5, 0, 0, 0, 0, 0, 0, 0);
    repeat (4) nop();
    run_to(5);
    cyc(0, 0, 3, 1, 1, 0, 0, 0, 0);
    cyc(0, 6, 0, 0, 0, 1, 1, 0, 0);
    cyc(0, 1, 2, 0, 1, 0, 0, 0, 0);
    cyc(0, 6, 0, 0, 0, 1, 0, 0, 0);
    cyc(0, 1, 2, 0, 1, 0, 0, 0, 0);
    cyc(0, 6, 0, 0, 0, 1, 0, 1, 0);
    cyc(0, 4, 1, 0, 1, 0, 0, 0, 0);
    cyc(0, 3, 1, 0, 1, 0, 0, 0, 0);
    nop();
    cyc(0, 5, 0, 0, 0, 0, 0, 0, 1);
    cyc(1, 5, 0, 0, 0, 0, 0, 0, 0);
    run_to(5);
    cyc(0, 6, 0, 0, 0, 1, 1, 1, 0);
    nop();
    cyc(0, 15, 0, 0, 0, 0, 0, 0, 0);
    repeat (3) cyc(0, $urandom_range(0, 15), $urandom_range(0, 31), 1, 1, 0, 0, 0, 0);
    cyc(1, 5, 0, 0, 0, 0, 0, 0, 0);
    cyc(0, 2, 2, 0, 1, 0, 0, 0, 0);
    cyc(0, 3, 2, 0, 1, 0, 0, 0, 0);
    cyc(0, 0, 31, 1, 1, 0, 0, 0, 0);
    nop();
    repeat (3) nop();
    cyc(1, 5, 0, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 31, 1, 0, 0, 0, 0, 0);
    cyc(0, 15, 0, 0, 0, 0, 0, 0, 0);
    repeat (2) nop();
    repeat (500) begin
      int op, kind;
      bit uj, jt, ce;
      op = $urandom_range(0, 15);
      if (op == 15 && $urandom_range(0, 3) != 0) op = 5;
      kind = $urandom_range(0, 3);
      ce = kind == 0;
      jt = kind == 1 || kind == 2;
      uj = kind == 2 || (kind == 1 && op == 0);
      cyc($urandom_range(0, 3) == 0, op, $urandom_range(0, 31), uj, jt, ce,
          $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 99) < 2);
    end
    cyc(0, 5, 0, 0, 0, 0, 0, 0, 0);
    b = 0;
    while (q.size() > 0 && b < 10) begin
      @(posedge clk);
      b++;
    end
    if (q.size() > 0) begin
      checks++;
      fails++;
      $display("FAIL drain: %0d expected entries left unchecked", q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
